// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/gnt/rvalid bus between the MEM stage and data memory
interface mem_access_stage_if #(
    parameter int DataWidth = 32
);
    logic                 dmem_req;
    logic                 dmem_gnt;
    logic                 dmem_we;
    logic [3:0]           dmem_be;
    logic [DataWidth-1:0] dmem_addr;
    logic [DataWidth-1:0] dmem_wdata;
    logic                 dmem_rvalid;
    logic [DataWidth-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32 memory-access stage: load/store over req/gnt/rvalid with pipeline stall
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int DataWidth    = 32,
    parameter int RegAddrWidth = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    RegEn_IN,
    input  logic [DataWidth-1:0]    ALU_result_IN,
    input  logic [DataWidth-1:0]    Store_Data_IN,
    input  logic [RegAddrWidth-1:0] WB_REG_IN,
    input  logic                    Mem_to_Reg_IN,
    input  logic                    Mem_Read_IN,
    input  logic                    Mem_Write_IN,
    input  logic [2:0]              Funct3_IN,
    output logic                    RegEn_OUT,
    output logic [DataWidth-1:0]    ALU_result_OUT,
    output logic [DataWidth-1:0]    Mem_Data_OUT,
    output logic [RegAddrWidth-1:0] WB_REG_OUT,
    output logic                    Mem_to_Reg_OUT,
    output logic                    stall_o,
    mem_access_stage_if.master      dmem,
    output logic                    misalign_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [DataWidth-1:0] load_data_q, load_data_d;

    logic                 mem_op;
    logic                 is_store;
    logic [1:0]           lane;
    logic                 acc_byte;
    logic                 acc_half;
    logic                 misaligned;
    logic                 req;
    logic [3:0]           store_be;
    logic [DataWidth-1:0] store_wdata;
    logic [7:0]           rd_byte;
    logic [15:0]          rd_half;
    logic [DataWidth-1:0] load_ext;

    // Write wins when both read and write are set, so the access is a store.
    assign mem_op   = Mem_Read_IN | Mem_Write_IN;
    assign is_store = Mem_Write_IN;
    assign lane     = ALU_result_IN[1:0];

    // Stores only know SB/SH/SW; loads also have the unsigned byte/half forms.
    assign acc_byte = is_store ? (Funct3_IN == 3'b000)
                               : (Funct3_IN == 3'b000 || Funct3_IN == 3'b100);
    assign acc_half = is_store ? (Funct3_IN == 3'b001)
                               : (Funct3_IN == 3'b001 || Funct3_IN == 3'b101);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = mem_op & (acc_half ? lane[0] : (!acc_byte && lane != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = Store_Data_IN;
        if (acc_byte) begin
            store_be    = 4'b0001 << lane;
            store_wdata = {4{Store_Data_IN[7:0]}};
        end else if (acc_half) begin
            store_be    = lane[1] ? 4'b1100 : 4'b0011;
            store_wdata = {2{Store_Data_IN[15:0]}};
        end
    end

    always_comb begin
        case (lane)
            2'd1:    rd_byte = dmem.dmem_rdata[15:8];
            2'd2:    rd_byte = dmem.dmem_rdata[23:16];
            2'd3:    rd_byte = dmem.dmem_rdata[31:24];
            default: rd_byte = dmem.dmem_rdata[7:0];
        endcase
        rd_half = lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (Funct3_IN)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_ext = {24'd0, rd_byte};
            3'b101:  load_ext = {16'd0, rd_half};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_data_d = load_data_q;
        stall_o     = 1'b0;
        req         = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    stall_o = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                req     = 1'b1;
                if (dmem.dmem_gnt) begin
                    state_d = is_store ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (dmem.dmem_rvalid) begin
                    load_data_d = load_ext;
                    state_d     = DONE;
                end
            end
            // EX/MEM advances on the next edge, so DONE never re-issues the same op.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign misalign_o = (state_q == IDLE) & misaligned;

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req & is_store;
    assign dmem.dmem_be    = is_store ? store_be : 4'b1111;
    assign dmem.dmem_addr  = {ALU_result_IN[DataWidth-1:2], 2'b00};
    assign dmem.dmem_wdata = store_wdata;

    assign RegEn_OUT      = RegEn_IN & ~stall_o & ~misalign_o;
    assign ALU_result_OUT = ALU_result_IN;
    assign WB_REG_OUT     = WB_REG_IN;
    assign Mem_to_Reg_OUT = Mem_to_Reg_IN;
    assign Mem_Data_OUT   = (state_q == DONE && !is_store) ? load_data_q : '0;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage against a word-memory model
module tb_mem_access_stage;
    localparam int DW = 32;
    localparam int RW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          RegEn_IN = 1'b0;
    logic [DW-1:0] ALU_result_IN = '0;
    logic [DW-1:0] Store_Data_IN = '0;
    logic [RW-1:0] WB_REG_IN = '0;
    logic          Mem_to_Reg_IN = 1'b0;
    logic          Mem_Read_IN = 1'b0;
    logic          Mem_Write_IN = 1'b0;
    logic [2:0]    Funct3_IN = '0;
    logic          RegEn_OUT;
    logic [DW-1:0] ALU_result_OUT;
    logic [DW-1:0] Mem_Data_OUT;
    logic [RW-1:0] WB_REG_OUT;
    logic          Mem_to_Reg_OUT;
    logic          stall_o;
    logic          misalign_o;

    mem_access_stage_if #(.DataWidth(DW)) dmem ();

    mem_access_stage #(.DataWidth(DW), .RegAddrWidth(RW)) dut (
        .clock          (clock),
        .reset          (reset),
        .RegEn_IN       (RegEn_IN),
        .ALU_result_IN  (ALU_result_IN),
        .Store_Data_IN  (Store_Data_IN),
        .WB_REG_IN      (WB_REG_IN),
        .Mem_to_Reg_IN  (Mem_to_Reg_IN),
        .Mem_Read_IN    (Mem_Read_IN),
        .Mem_Write_IN   (Mem_Write_IN),
        .Funct3_IN      (Funct3_IN),
        .RegEn_OUT      (RegEn_OUT),
        .ALU_result_OUT (ALU_result_OUT),
        .Mem_Data_OUT   (Mem_Data_OUT),
        .WB_REG_OUT     (WB_REG_OUT),
        .Mem_to_Reg_OUT (Mem_to_Reg_OUT),
        .stall_o        (stall_o),
        .dmem           (dmem),
        .misalign_o     (misalign_o)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [31:0] mem [0:1023];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Load result from the addressed word: pick the lane arithmetically, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
        int unsigned o = addr % 4;
        int unsigned b = (word >> (8 * o)) % 256;
        int unsigned h = (word >> (16 * (o / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic void ref_store(input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] d, output logic [3:0] be,
                                      output logic [31:0] wd);
        int unsigned o = addr % 4;
        if (f3 == 3'd0) begin
            be = 4'(1 << o);
            wd = (d % 256) * 32'h01010101;
        end else if (f3 == 3'd1) begin
            be = 4'(3 << (2 * (o / 2)));
            wd = (d % 65536) * 32'h00010001;
        end else begin
            be = 4'hF;
            wd = d;
        end
    endfunction

    // Presents one EX/MEM op at posedge+1, acts as the memory slave, returns at posedge+1.
    task automatic do_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rdst,
                         input logic regen, input logic m2r, input int gd, input int rvd);
        bit          is_mem = rd | wr;
        int          exp_stall = !is_mem ? 0 : (wr ? gd + 2 : gd + 2 + rvd);
        int          exp_req = is_mem ? gd + 1 : 0;
        logic [3:0]  ebe = 4'hF;
        logic [31:0] ewd = '0;
        logic [31:0] edata = '0;
        logic [9:0]  idx = addr[11:2];
        int          stall_cnt = 0;
        int          req_cnt = 0;
        int          wcnt = 0;
        int          cyc = 0;
        bit          waiting = 0;
        bit          done = 0;
        RegEn_IN = regen; ALU_result_IN = addr; Store_Data_IN = sd; WB_REG_IN = rdst;
        Mem_to_Reg_IN = m2r; Mem_Read_IN = rd; Mem_Write_IN = wr; Funct3_IN = f3;
        if (wr) ref_store(f3, addr, sd, ebe, ewd);
        else if (rd) edata = ref_load(mem[idx], f3, addr);
        while (!done && cyc < 40) begin
            dmem.dmem_gnt    = 1'b0;
            dmem.dmem_rvalid = 1'b0;
            dmem.dmem_rdata  = $urandom;
            if (waiting) begin
                wcnt++;
                if (wcnt == rvd) begin
                    dmem.dmem_rvalid = 1'b1;
                    dmem.dmem_rdata  = mem[idx];
                end
            end
            if (dmem.dmem_req) begin
                if (req_cnt == gd) dmem.dmem_gnt = 1'b1;
                req_cnt++;
            end
            @(negedge clock);
            if (dmem.dmem_req) begin
                check({tag, " addr"}, dmem.dmem_addr, addr & 32'hFFFF_FFFC);
                check({tag, " be"}, 32'(dmem.dmem_be), 32'(ebe));
                check({tag, " we"}, 32'(dmem.dmem_we), 32'(wr));
                if (wr) check({tag, " wdata"}, dmem.dmem_wdata, ewd);
            end
            if (stall_o) begin
                stall_cnt++;
                check({tag, " bubble regen"}, 32'(RegEn_OUT), 32'd0);
            end else begin
                done = 1;
                check({tag, " regen"}, 32'(RegEn_OUT), 32'(regen));
                check({tag, " alu"}, ALU_result_OUT, addr);
                check({tag, " wbreg"}, 32'(WB_REG_OUT), 32'(rdst));
                check({tag, " m2r"}, 32'(Mem_to_Reg_OUT), 32'(m2r));
                check({tag, " data"}, Mem_Data_OUT, edata);
                check({tag, " misalign"}, 32'(misalign_o), 32'd0);
                check({tag, " req idle"}, 32'(dmem.dmem_req), 32'd0);
            end
            if (dmem.dmem_gnt) begin
                if (wr) begin
                    for (int i = 0; i < 4; i++)
                        if (ebe[i]) mem[idx][8*i +: 8] = ewd[8*i +: 8];
                end else begin
                    waiting = 1;
                end
            end
            if (dmem.dmem_rvalid) waiting = 0;
            @(posedge clock);
            #1;
            cyc++;
        end
        dmem.dmem_gnt    = 1'b0;
        dmem.dmem_rvalid = 1'b0;
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " stall cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, " req cycles"}, 32'(req_cnt), 32'(exp_req));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dmem.dmem_gnt    = 1'b0;
        dmem.dmem_rvalid = 1'b0;
        dmem.dmem_rdata  = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        repeat (2) @(negedge clock);
        check("rst req", 32'(dmem.dmem_req), 32'd0);
        check("rst we", 32'(dmem.dmem_we), 32'd0);
        check("rst stall", 32'(stall_o), 32'd0);
        check("rst misalign", 32'(misalign_o), 32'd0);
        check("rst data", Mem_Data_OUT, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        mem[32'h100 >> 2] = 32'h80FF7F01;
        do_op("lb101", 1, 0, 3'b000, 32'h101, 32'h0, 5'd3, 1, 1, 0, 1);
        do_op("lb102", 1, 0, 3'b000, 32'h102, 32'h0, 5'd4, 1, 1, 0, 1);
        do_op("sh202", 0, 1, 3'b001, 32'h202, 32'h0000BEEF, 5'd0, 0, 0, 0, 1);
        check("sh202 mem", mem[32'h200 >> 2] >> 16, 32'h0000BEEF);
        mem[32'h300 >> 2] = 32'hCAFEF00D;
        do_op("lw300slow", 1, 0, 3'b010, 32'h300, 32'h0, 5'd7, 1, 1, 3, 2);
        do_op("add", 0, 0, 3'b000, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 1);
        do_op("rdwr", 1, 1, 3'b010, 32'h40C, 32'h13572468, 5'd0, 0, 0, 1, 1);
        do_op("lw40c", 1, 0, 3'b010, 32'h40C, 32'h0, 5'd9, 1, 1, 0, 1);

        // Reset while REQ is up must drop dmem_req without waiting for a clock.
        RegEn_IN = 1; ALU_result_IN = 32'h300; Mem_Read_IN = 1; Mem_Write_IN = 0; Funct3_IN = 3'b010;
        @(posedge clock); #1;
        check("req before rst", 32'(dmem.dmem_req), 32'd1);
        #2 reset = 1'b0; Mem_Read_IN = 0;
        #1 check("req async drop", 32'(dmem.dmem_req), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Reset in WAIT, then a stale rvalid after release.
        Mem_Read_IN = 1;
        @(posedge clock); #1;
        dmem.dmem_gnt = 1'b1;
        @(posedge clock); #1;
        dmem.dmem_gnt = 1'b0;
        #2 reset = 1'b0; Mem_Read_IN = 0;
        #1 check("wait rst stall", 32'(stall_o), 32'd0);
        check("wait rst req", 32'(dmem.dmem_req), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = 32'hDEADBEEF;
        @(negedge clock);
        check("stale rvalid stall", 32'(stall_o), 32'd0);
        check("stale rvalid data", Mem_Data_OUT, 32'd0);
        @(posedge clock); #1;
        dmem.dmem_rvalid = 1'b0;
        @(negedge clock);
        check("post stale stall", 32'(stall_o), 32'd0);
        check("post stale req", 32'(dmem.dmem_req), 32'd0);
        @(posedge clock); #1;
        do_op("lhu after rst", 1, 0, 3'b101, 32'h302, 32'h0, 5'd8, 1, 1, 0, 1);

`ifdef MISALIGN_TRAP_EN
        RegEn_IN = 1; ALU_result_IN = 32'h401; Mem_Read_IN = 1; Mem_Write_IN = 0; Funct3_IN = 3'b010;
        @(negedge clock);
        check("mis flag", 32'(misalign_o), 32'd1);
        check("mis req", 32'(dmem.dmem_req), 32'd0);
        check("mis stall", 32'(stall_o), 32'd0);
        check("mis regen", 32'(RegEn_OUT), 32'd0);
        @(posedge clock); #1;
        check("mis req next", 32'(dmem.dmem_req), 32'd0);
        Mem_Read_IN = 0;
        @(posedge clock); #1;
`else
        do_op("lw401", 1, 0, 3'b010, 32'h401, 32'h0, 5'd6, 1, 1, 0, 1);
`endif

        for (int n = 0; n < 60; n++) begin
            int          kind = $urandom_range(0, 9);
            logic        rd = 0;
            logic        wr = 0;
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [31:0] off = $urandom_range(0, 3);
            logic [31:0] addr;
            if (kind >= 6) begin
                wr = 1;
                rd = (kind == 9);
                f3 = 3'($urandom_range(0, 2));
            end else if (kind >= 2) begin
                rd = 1;
            end
            if (f3 == 3'd1 || (rd && !wr && f3 == 3'd5)) off = off & 32'd2;
            else if (!(f3 == 3'd0 || (rd && !wr && f3 == 3'd4))) off = 0;
            addr = (32'($urandom_range(0, 1023)) << 2) | off;
            do_op("rand", rd, wr, f3, addr, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage between the EX/MEM pipeline register and the MEM/WB register.
- Turns load/store control from EX/MEM into a req/gnt/rvalid transaction on the data-memory bus, then returns aligned, extended load data.
- Stalls upstream stages while a transaction is outstanding.
- Drives the RegEn/ALU result/Mem data/WB reg/Mem_to_Reg inputs of MEM/WB.

Parameters:
- DataWidth, 32, data/address width; RV32 byte-lane logic assumes 32.
- RegAddrWidth, 5, register-file index width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RegEn_IN  in  1  writeback enable from EX/MEM.
- ALU_result_IN  in  DataWidth  effective address, or ALU result for non-memory instructions.
- Store_Data_IN  in  DataWidth  rs2 value for stores.
- WB_REG_IN  in  RegAddrWidth  destination register.
- Mem_to_Reg_IN  in  1  writeback selects memory data.
- Mem_Read_IN  in  1  load instruction.
- Mem_Write_IN  in  1  store instruction.
- Funct3_IN  in  3  access size/sign (RV32I encoding).
- RegEn_OUT  out  1  to MEM/WB.
- ALU_result_OUT  out  DataWidth  to MEM/WB.
- Mem_Data_OUT  out  DataWidth  aligned, extended load data.
- WB_REG_OUT  out  RegAddrWidth  to MEM/WB.
- Mem_to_Reg_OUT  out  1  to MEM/WB.
- stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- dmem_req  out  1  bus request.
- dmem_gnt  in  1  request accepted.
- dmem_we  out  1  write enable.
- dmem_be  out  4  byte enables.
- dmem_addr  out  DataWidth  word-aligned address {addr[31:2],2'b00}.
- dmem_wdata  out  DataWidth  lane-replicated store data.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  DataWidth  read data.
- misalign_o  out  1  misaligned-access flag; see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; dmem_req, dmem_we, stall_o, misalign_o = 0; load data register = 0. With no memory op pending, RegEn_OUT, ALU_result_OUT, WB_REG_OUT and Mem_to_Reg_OUT are combinational pass-through of their inputs.
- mem_op = Mem_Read_IN | Mem_Write_IN. A non-memory op passes through combinationally: no stall, Mem_Data_OUT = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE & mem_op → REQ; stall_o=1 combinationally in that same cycle.
  - REQ: dmem_req=1, with addr/we/be/wdata held stable until gnt. On gnt: store → DONE, load → WAIT.
  - WAIT: on rvalid, capture the extracted load data → DONE. rvalid never arrives in the gnt cycle; earliest is the cycle after.
  - DONE: stall_o=0; outputs present the captured data; next edge loads MEM/WB and EX/MEM advances; DONE → IDLE unconditionally, so the same op is never reissued.
- stall_o = (IDLE & mem_op) | REQ | WAIT. While stall_o=1, RegEn_OUT is forced to 0, inserting a bubble into MEM/WB.
- Load latency: at least 3 cycles per load (IDLE, REQ, WAIT, DONE with zero-wait gnt and rvalid).
- Store latency: 2 cycles minimum.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{byte}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{half}}.
  - SW: be = 4'b1111.
- Load extraction by Funct3, lane selected by addr[1:0]:
  - 000 LB: sign-extend.
  - 001 LH: sign-extend.
  - 010 LW.
  - 100 LBU: zero-extend.
  - 101 LHU: zero-extend.
  - Other values: treated as LW.
- Loads drive dmem_be = 4'b1111.
- dmem_rvalid outside WAIT is ignored, e.g. a stale response after reset.
- Reset mid-transaction: return to IDLE immediately; dmem_req drops asynchronously.
- Mem_Read_IN and Mem_Write_IN both high: treated as a store.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: an access is misaligned when an LH/LHU/SH has addr[0]=1, or an LW/SW has addr[1:0]≠0.
  - A misaligned access issues no bus request and causes no stall.
  - misalign_o=1 combinationally for the cycle the access is presented in IDLE.
  - RegEn_OUT=0 for that cycle; a store performs no write.
- Not defined: misalign_o is tied to 0. The access proceeds using only the lane bits defined above; halfword uses addr[1], word ignores addr[1:0].

Test Plan:
- Pre-load mem[0x100]=0x80FF7F01; LB addr 0x101 with gnt and rvalid immediate → Mem_Data_OUT=0x0000007F. Then LB addr 0x102 → 0xFFFFFFFF. stall_o high 3 cycles per load.
- SH rs2=0x0000BEEF, addr 0x202 → dmem_be=4'b1100, dmem_wdata=0xBEEFBEEF, dmem_we=1. No rvalid is waited for; stall_o high 2 cycles.
- LW addr 0x300, gnt delayed 3 cycles and rvalid a further 2 cycles → dmem_req and addr stable throughout. Stall lasts 7 cycles; RegEn_OUT=0 throughout; DONE presents the data with RegEn_OUT=1 exactly once.
- ADD result 0x1234, rd=5, no mem op → same-cycle pass-through; stall_o=0; Mem_Data_OUT=0.
- Assert reset while in WAIT, then pulse rvalid after release → state IDLE, no stall, data register=0, stale rvalid ignored.
- With MISALIGN_TRAP_EN: LW addr 0x401 → misalign_o=1, dmem_req never asserted, RegEn_OUT=0. Without the macro: the same access reads word 0x400.
